bsg_serializer_one: RTL and testbench



---
 rtl/bsg_serializer_one.sv | 96 +++++++++
 tb/tb_bsg_serializer_one.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_serializer_one.sv
// bsg_serializer_one: captures one word over valid/yumi and
// emits it as ratio_p equal chunks over valid/ready.
module bsg_serializer_one #(
  parameter int width_p     = 16,
  parameter int ratio_p     = 4,
  parameter int msb_first_p = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       yumi_o,
  output logic                       v_o,
  output logic [width_p/ratio_p-1:0] data_o,
  output logic                       last_o,
  input  logic                       ready_i
);

  localparam int cw_lp    = width_p / ratio_p;
  localparam int cnt_w_lp = (ratio_p > 1) ? $clog2(ratio_p) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e               state_r, state_n;
  logic [cnt_w_lp-1:0]  cnt_r, cnt_n;
  logic [width_p-1:0]   word_r, word_n;
  logic                 busy, send, done;
  logic [cw_lp-1:0]     chunk_a [ratio_p];

  assign busy   = (state_r == SEND);
  assign v_o    = busy;
  assign last_o = busy & (cnt_r == cnt_w_lp'(ratio_p - 1));
  assign send   = v_o & ready_i;
  assign done   = send & last_o;
  assign yumi_o = v_i & ~reset_i & (~busy | done);

  // Chunk g of the captured word, in the configured order.
  for (genvar g = 0; g < ratio_p; g++) begin : g_chunk
    if (msb_first_p != 0) begin : g_msb
      assign chunk_a[g] = word_r[width_p-1-g*cw_lp -: cw_lp];
    end else begin : g_lsb
      assign chunk_a[g] = word_r[g*cw_lp +: cw_lp];
    end
  end

  assign data_o = chunk_a[cnt_r];

  // State register; reset discards any partially sent word.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      word_r  <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      word_r  <= word_n;
    end
  end

  // Next state: capture on idle or on the last chunk leaving.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    word_n  = word_r;
    unique case (state_r)
      IDLE: begin
        if (v_i) begin
          word_n  = data_i;
          cnt_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (done) begin
          cnt_n = '0;
          if (v_i) begin
            word_n = data_i;
          end else begin
            state_n = IDLE;
          end
        end else if (send) begin
          cnt_n = cnt_r + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (ratio_p == 1) begin
      cnt_n = '0;
    end
  end

endmodule

// File: tb/tb_bsg_serializer_one.sv
// tb_bsg_serializer_one: directed table plus msb-first and
// ratio-1 scoreboard sequences.
module tb_bsg_serializer_one;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // lsb-first, ratio 4
  logic        rst0, v0, yumi0, vo0, last0, rdy0;
  logic [15:0] d0;
  logic [3:0]  dout0;

  // msb-first, ratio 4
  logic        rst1, v1, yumi1, vo1, last1, rdy1;
  logic [15:0] d1;
  logic [3:0]  dout1;

  // ratio 1
  logic        rst2, v2, yumi2, vo2, last2, rdy2;
  logic [15:0] d2;
  logic [15:0] dout2;

  bsg_serializer_one #(.width_p(16), .ratio_p(4), .msb_first_p(0)) dut0 (
    .clk_i(clk), .reset_i(rst0), .v_i(v0), .data_i(d0),
    .yumi_o(yumi0), .v_o(vo0), .data_o(dout0), .last_o(last0),
    .ready_i(rdy0));

  bsg_serializer_one #(.width_p(16), .ratio_p(4), .msb_first_p(1)) dut1 (
    .clk_i(clk), .reset_i(rst1), .v_i(v1), .data_i(d1),
    .yumi_o(yumi1), .v_o(vo1), .data_o(dout1), .last_o(last1),
    .ready_i(rdy1));

  bsg_serializer_one #(.width_p(16), .ratio_p(1), .msb_first_p(0)) dut2 (
    .clk_i(clk), .reset_i(rst2), .v_i(v2), .data_i(d2),
    .yumi_o(yumi2), .v_o(vo2), .data_o(dout2), .last_o(last2),
    .ready_i(rdy2));

  typedef struct packed {
    logic        rst;
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        yumi;
    logic        vo;
    logic [3:0]  dat;
    logic        lst;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic v,
                              input logic [15:0] d, input logic rdy,
                              input logic yumi, input logic vo,
                              input logic [3:0] dat, input logic lst);
    vec_t r;
    r = '{rst, v, d, rdy, yumi, vo, dat, lst};
    return r;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sb[$];
  logic        prev_yumi;
  logic [15:0] prev_word;
  logic [3:0]  msb_exp [4];

  initial begin
    rst0 = 1; v0 = 0; d0 = 0; rdy0 = 1;
    rst1 = 1; v1 = 0; d1 = 0; rdy1 = 1;
    rst2 = 1; v2 = 0; d2 = 0; rdy2 = 1;

    // rst v data rdy | yumi vo dat last
    tbl.push_back(mk(1, 1, 16'hABCD, 1, 0, 0, 4'h0, 0));
    // single word
    tbl.push_back(mk(0, 1, 16'hABCD, 1, 1, 0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'hD, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'hC, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'hB, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'hA, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 4'hD, 0));
    // back-to-back
    tbl.push_back(mk(0, 1, 16'h1234, 1, 1, 0, 4'hD, 0));
    tbl.push_back(mk(0, 1, 16'h5678, 1, 0, 1, 4'h4, 0));
    tbl.push_back(mk(0, 1, 16'h5678, 1, 0, 1, 4'h3, 0));
    tbl.push_back(mk(0, 1, 16'h5678, 1, 0, 1, 4'h2, 0));
    tbl.push_back(mk(0, 1, 16'h5678, 1, 1, 1, 4'h1, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'h8, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'h7, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'h6, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'h5, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 4'h8, 0));
    // backpressure
    tbl.push_back(mk(0, 1, 16'hABCD, 1, 1, 0, 4'h8, 0));
    tbl.push_back(mk(0, 1, 16'h1111, 1, 0, 1, 4'hD, 0));
    tbl.push_back(mk(0, 1, 16'h1111, 0, 0, 1, 4'hC, 0));
    tbl.push_back(mk(0, 1, 16'h1111, 0, 0, 1, 4'hC, 0));
    tbl.push_back(mk(0, 1, 16'h1111, 0, 0, 1, 4'hC, 0));
    tbl.push_back(mk(0, 1, 16'h1111, 1, 0, 1, 4'hC, 0));
    tbl.push_back(mk(0, 1, 16'h1111, 1, 0, 1, 4'hB, 0));
    tbl.push_back(mk(0, 1, 16'h1111, 0, 0, 1, 4'hA, 1));
    tbl.push_back(mk(0, 1, 16'h1111, 1, 1, 1, 4'hA, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'h1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'h1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'h1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'h1, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 4'h1, 0));
    // reset mid-word
    tbl.push_back(mk(0, 1, 16'hABCD, 1, 1, 0, 4'h1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'hD, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'hC, 0));
    tbl.push_back(mk(1, 1, 16'h00F0, 1, 0, 1, 4'hB, 0));
    tbl.push_back(mk(0, 1, 16'h00F0, 1, 1, 0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'h0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'hF, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'h0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 4'h0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 4'h0, 0));

    nxt();
    nxt();

    foreach (tbl[i]) begin
      rst0 = tbl[i].rst;
      v0   = tbl[i].v;
      d0   = tbl[i].d;
      rdy0 = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d yumi", i), 32'(yumi0), 32'(tbl[i].yumi));
      chk($sformatf("row%0d v_o", i), 32'(vo0), 32'(tbl[i].vo));
      chk($sformatf("row%0d data_o", i), 32'(dout0), 32'(tbl[i].dat));
      chk($sformatf("row%0d last_o", i), 32'(last0), 32'(tbl[i].lst));
      nxt();
    end

    // msb-first word
    msb_exp[0] = 4'hA; msb_exp[1] = 4'hB;
    msb_exp[2] = 4'hC; msb_exp[3] = 4'hD;
    rst1 = 0; v1 = 1; d1 = 16'hABCD; rdy1 = 1;
    @(negedge clk);
    chk("msb yumi", 32'(yumi1), 32'd1);
    chk("msb idle v_o", 32'(vo1), 32'd0);
    nxt();
    v1 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("msb c%0d v_o", k), 32'(vo1), 32'd1);
      chk($sformatf("msb c%0d data", k), 32'(dout1), 32'(msb_exp[k]));
      chk($sformatf("msb c%0d last", k), 32'(last1), 32'(k == 3));
      nxt();
    end
    @(negedge clk);
    chk("msb end v_o", 32'(vo1), 32'd0);
    nxt();

    // ratio 1: random handshakes against a scoreboard
    rst2 = 0;
    prev_yumi = 0;
    prev_word = 0;
    v2 = 1'($urandom_range(0, 1));
    d2 = 16'($urandom);
    for (int c = 0; c < 300; c++) begin
      rdy2 = 1'($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_yumi) begin
        chk("r1 latency v_o", 32'(vo2), 32'd1);
        chk("r1 latency data", 32'(dout2), 32'(prev_word));
      end
      chk("r1 last", 32'(last2), 32'(vo2));
      chk("r1 yumi", 32'(yumi2), 32'(v2 & (~vo2 | rdy2)));
      if (vo2 && rdy2) begin
        if (sb.size() == 0) begin
          chk("r1 spurious", 32'(dout2), 32'hFFFF_FFFF);
        end else begin
          chk("r1 data", 32'(dout2), 32'(sb.pop_front()));
        end
      end
      prev_yumi = yumi2;
      prev_word = d2;
      if (yumi2) sb.push_back(d2);
      nxt();
      if (!v2 || prev_yumi) begin
        v2 = 1'($urandom_range(0, 1));
        d2 = 16'($urandom);
      end
    end
    v2 = 0;
    rdy2 = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (vo2) begin
        if (sb.size() == 0) begin
          chk("r1 drain spurious", 32'(dout2), 32'hFFFF_FFFF);
        end else begin
          chk("r1 drain data", 32'(dout2), 32'(sb.pop_front()));
        end
      end
      nxt();
    end
    @(negedge clk);
    chk("r1 drained v_o", 32'(vo2), 32'd0);
    chk("r1 lost words", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
